spi_reg_slave: RTL and testbench

//   SPI mode-0 slave that turns host frames into peripheral register transactions for the

---
 rtl/spi_reg_slave.sv | 160 ++++++++++++++++
 tb/tb_spi_reg_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave. A 16-bit header (rw, width, addr) is followed by
// 8/16/32 data bits: shifted in and strobed out for writes, or fetched from the
// peripheral and shifted out on MISO for reads. SPI inputs are pre-synchronised.
module spi_reg_slave #(
   parameter int ADDR_W     = 6,
   parameter int REG_W      = 32,
   parameter int RD_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [REG_W-1:0]  reg_data_o,
   output logic              reg_data_o_dv,
   output logic              reg_addr_v,
   input  logic [REG_W-1:0]  reg_data_i,
   input  logic              reg_data_i_dv,
   output logic              reg_rw,
   output logic [1:0]        txn_width,
   output logic              rd_timeout
);
   localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, HDR, WDATA, RREQ, RDATA, DONE} state_t;

   state_t           state, state_nx;
   logic             sck_q, rise, fall;
   logic [5:0]       bit_cnt, nbits;
   logic [TMO_W-1:0] tmo_cnt;
   logic [REG_W-1:0] sh, sh_nx, wr_val, rd_cap;
   logic             hdr_last, data_last, tmo_hit;

   assign rise      = spi_clk & ~sck_q;
   assign fall      = ~spi_clk & sck_q;
   assign sh_nx     = {sh[REG_W-2:0], spi_mosi};
   assign hdr_last  = rise && (bit_cnt == 6'd15);
   assign data_last = rise && (bit_cnt == nbits - 6'd1);
   assign tmo_hit   = (tmo_cnt == TMO_W'(RD_TIMEOUT - 1));

   // MISO carries the head of the read shift register only while read data is
   // being returned; state reset clears it without needing a clock edge.
   assign spi_miso = (state == RDATA) & sh[REG_W-1];

   // Data bit count and lane extraction for the latched width (11 acts as word).
   always_comb begin
      nbits  = 6'(REG_W);
      wr_val = sh_nx;
      rd_cap = reg_data_i;
      case (txn_width)
         2'b00: begin
            nbits  = 6'd8;
            wr_val = {{(REG_W-8){1'b0}}, sh_nx[7:0]};
            rd_cap = {reg_data_i[7:0], {(REG_W-8){1'b0}}};
         end
         2'b01: begin
            nbits  = 6'd16;
            wr_val = {{(REG_W-16){1'b0}}, sh_nx[15:0]};
            rd_cap = {reg_data_i[15:0], {(REG_W-16){1'b0}}};
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: CS high aborts from anywhere; dv beats timeout on a tie.
   always_comb begin
      state_nx = state;
      if (spi_cs_n) state_nx = IDLE;
      else begin
         case (state)
            IDLE:    state_nx = HDR;
            HDR:     if (hdr_last) state_nx = sh_nx[15] ? WDATA : RREQ;
            WDATA:   if (data_last) state_nx = DONE;
            RREQ:    if (reg_data_i_dv || tmo_hit) state_nx = RDATA;
            RDATA:   if (data_last) state_nx = DONE;
            default: ;
         endcase
      end
   end

   // Datapath: SCK history, shifting, header latch, write strobe, read request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q         <= 1'b0;
         sh            <= '0;
         bit_cnt       <= '0;
         tmo_cnt       <= '0;
         reg_addr      <= '0;
         reg_data_o    <= '0;
         reg_data_o_dv <= 1'b0;
         reg_addr_v    <= 1'b0;
         reg_rw        <= 1'b0;
         txn_width     <= 2'b00;
         rd_timeout    <= 1'b0;
      end else begin
         sck_q         <= spi_clk;
         reg_data_o_dv <= 1'b0;
         if (spi_cs_n) begin
            reg_addr_v <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  sh         <= '0;
                  bit_cnt    <= '0;
                  tmo_cnt    <= '0;
                  rd_timeout <= 1'b0;
               end
               HDR: if (rise) begin
                  sh <= sh_nx;
                  if (hdr_last) begin
                     reg_rw     <= sh_nx[15];
                     txn_width  <= sh_nx[9:8];
                     reg_addr   <= sh_nx[ADDR_W-1:0];
                     reg_addr_v <= ~sh_nx[15];
                     bit_cnt    <= '0;
                     tmo_cnt    <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                  end
               end
               WDATA: if (rise) begin
                  sh      <= sh_nx;
                  bit_cnt <= bit_cnt + 6'd1;
                  if (data_last) begin
                     reg_data_o    <= wr_val;
                     reg_data_o_dv <= 1'b1;
                  end
               end
               RREQ: begin
                  if (reg_data_i_dv) begin
                     sh         <= rd_cap;
                     reg_addr_v <= 1'b0;
                  end else if (tmo_hit) begin
                     sh         <= '1;
                     reg_addr_v <= 1'b0;
                     rd_timeout <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end
               RDATA: begin
                  if (rise) bit_cnt <= bit_cnt + 6'd1;
                  // The header's trailing fall can land here on a fast dv; only
                  // advance after the host has sampled at least one data bit.
                  if (fall && bit_cnt != 6'd0) sh <= {sh[REG_W-2:0], 1'b0};
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed frames plus randomized read/write frames
// against a frame-level model (masked data, request length, timeout flag).
module tb_spi_reg_slave;
   logic        clk = 1'b0, rst = 1'b1;
   logic        spi_cs_n = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
   logic        spi_miso;
   logic [5:0]  reg_addr;
   logic [31:0] reg_data_o;
   logic [31:0] reg_data_i = 32'h0;
   logic        reg_data_o_dv, reg_addr_v, reg_rw, rd_timeout;
   logic        reg_data_i_dv = 1'b0;
   logic [1:0]  txn_width;

   int          total = 0, bad = 0;
   int          dv_cnt = 0, hi_cnt = 0, dv_delay = 0;
   bit          dv_en = 1'b0;
   time         dv_t = 0, raise_t = 0;
   logic [31:0] dv_data = 32'h0, last_wr = 32'h0;

   spi_reg_slave dut (
      .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_addr(reg_addr),
      .reg_data_o(reg_data_o), .reg_data_o_dv(reg_data_o_dv),
      .reg_addr_v(reg_addr_v), .reg_data_i(reg_data_i),
      .reg_data_i_dv(reg_data_i_dv), .reg_rw(reg_rw),
      .txn_width(txn_width), .rd_timeout(rd_timeout)
   );

   always #5 clk = ~clk;

   // Peripheral model: answers a request after dv_delay cycles of reg_addr_v,
   // and records write strobes and request length.
   always @(negedge clk) begin
      reg_data_i_dv = 1'b0;
      if (spi_cs_n) hi_cnt = 0;
      else if (reg_addr_v) begin
         if (dv_en && hi_cnt == dv_delay) reg_data_i_dv = 1'b1;
         hi_cnt++;
      end
      if (reg_data_o_dv) begin
         dv_cnt++;
         dv_t    = $time;
         dv_data = reg_data_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int nb(input logic [1:0] w);
      return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
   endfunction

   function automatic logic [31:0] msk(input int n);
      return (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
   endfunction

   // One SCK period at clk/8; host samples MISO as it raises SCK.
   task automatic xbit(input logic b, output logic r);
      spi_mosi = b;
      repeat (4) @(negedge clk);
      r       = spi_miso;
      spi_clk = 1'b1;
      raise_t = $time;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] v, input int n, output logic [31:0] rx);
      logic r;
      rx = 32'h0;
      for (int i = n - 1; i >= 0; i--) begin
         xbit(v[i], r);
         rx = {rx[30:0], r};
      end
   endtask

   task automatic do_write(input logic [1:0] w, input logic [5:0] a, input logic [31:0] d);
      int n, c0;
      logic [31:0] rx, exp;
      n   = nb(w);
      exp = d & msk(n);
      spi_cs_n = 1'b0;
      repeat (3) @(negedge clk);
      xfer({16'h0, 1'b1, 5'b0, w, 2'b0, a}, 16, rx);
      c0 = dv_cnt;
      xfer(d, n, rx);
      repeat (3) @(negedge clk);
      chk("wr_strobes", 32'(dv_cnt - c0), 32'd1);
      chk("wr_strobe_lat", 32'(dv_t - raise_t), 32'd10);
      chk("wr_data_at_strobe", dv_data, exp);
      chk("wr_hdr", 32'({reg_rw, txn_width, reg_addr}), 32'({1'b1, w, a}));
      chk("wr_rd_timeout_clr", 32'(rd_timeout), 32'd0);
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("wr_data_hold", reg_data_o, exp);
      chk("wr_hdr_hold", 32'({reg_rw, txn_width, reg_addr}), 32'({1'b1, w, a}));
      last_wr = exp;
   endtask

   task automatic do_read(input logic [1:0] w, input logic [5:0] a, input logic [31:0] d,
                          input int dly, input bit en);
      int n, k;
      bit to;
      logic [31:0] rx, exp;
      n   = nb(w);
      to  = !en;
      exp = to ? msk(n) : (d & msk(n));
      reg_data_i = d;
      dv_delay   = dly;
      dv_en      = en;
      spi_cs_n   = 1'b0;
      repeat (3) @(negedge clk);
      xfer({16'h0, 1'b0, 5'b0, w, 2'b0, a}, 16, rx);
      k = 0;
      while (reg_addr_v && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("rd_req_bounded", 32'(k < 400), 32'd1);
      repeat (2) @(negedge clk);
      chk("rd_req_cycles", 32'(hi_cnt), to ? 32'd255 : 32'(dly + 1));
      chk("rd_timeout_flag", 32'(rd_timeout), 32'(to));
      chk("rd_hdr", 32'({reg_rw, txn_width, reg_addr}), 32'({1'b0, w, a}));
      xfer(32'h0, n, rx);
      chk("rd_miso_data", rx, exp);
      repeat (2) @(negedge clk);
      chk("rd_miso_done", 32'(spi_miso), 32'd0);
      spi_cs_n = 1'b1;
      dv_en    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rd_timeout_sticky", 32'(rd_timeout), 32'(to));
   endtask

   initial begin
      logic [31:0] rx, d;
      logic [1:0]  w;
      logic [5:0]  a;
      int          c0, k;

      repeat (3) @(negedge clk);
      chk("rst_miso", 32'(spi_miso), 32'd0);
      chk("rst_addr", 32'(reg_addr), 32'd0);
      chk("rst_wdata", reg_data_o, 32'd0);
      chk("rst_strobe", 32'(reg_data_o_dv), 32'd0);
      chk("rst_req", 32'(reg_addr_v), 32'd0);
      chk("rst_rw_width", 32'({reg_rw, txn_width}), 32'd0);
      chk("rst_timeout", 32'(rd_timeout), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      do_write(2'b10, 6'h05, 32'hDEAD_BEEF);
      do_write(2'b00, 6'h3F, 32'h0000_00A5);
      do_read(2'b01, 6'h10, 32'h1234_ABCD, 3, 1'b1);
      do_read(2'b10, 6'h2A, 32'h1357_9BDF, 0, 1'b0);
      spi_cs_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("to_clr_on_cs_fall", 32'(rd_timeout), 32'd0);
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);

      // Word write cut off after 30 data bits.
      c0 = dv_cnt;
      spi_cs_n = 1'b0;
      repeat (3) @(negedge clk);
      xfer(32'h0000_8205, 16, rx);
      xfer(32'h1234_5678, 30, rx);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_strobe", 32'(dv_cnt - c0), 32'd0);
      chk("abort_data_kept", reg_data_o, last_wr);
      chk("abort_addr_kept", 32'(reg_addr), 32'h05);
      do_write(2'b00, 6'h02, 32'h0000_005A);

      // CS glitch with no SCK, then a normal frame.
      spi_cs_n = 1'b0;
      repeat (3) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      do_write(2'b01, 6'h11, 32'h0000_C3A5);
      do_read(2'b00, 6'h01, 32'hFFFF_FF81, 0, 1'b1);

      for (int i = 0; i < 20; i++) begin
         w = 2'($urandom_range(0, 3));
         a = 6'($urandom_range(0, 63));
         d = $urandom;
         if ($urandom_range(0, 1) == 1) do_write(w, a, d);
         else do_read(w, a, d, int'($urandom_range(0, 40)), ($urandom_range(0, 5) != 0));
      end

      // Async reset while a request is outstanding.
      reg_data_i = 32'hFFFF_FFFF;
      dv_en      = 1'b0;
      spi_cs_n   = 1'b0;
      repeat (3) @(negedge clk);
      xfer(32'h0000_0207, 16, rx);
      repeat (5) @(negedge clk);
      chk("rst_pre_req", 32'(reg_addr_v), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_req", 32'(reg_addr_v), 32'd0);
      chk("rst_async_miso", 32'(spi_miso), 32'd0);
      chk("rst_async_addr", 32'(reg_addr), 32'd0);
      spi_cs_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Async reset while returning read data with MISO high.
      reg_data_i = 32'h0000_8000;
      dv_delay   = 0;
      dv_en      = 1'b1;
      spi_cs_n   = 1'b0;
      repeat (3) @(negedge clk);
      xfer(32'h0000_0103, 16, rx);
      k = 0;
      while (reg_addr_v && k < 400) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      chk("rdata_miso_msb", 32'(spi_miso), 32'd1);
      dv_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_rdata_miso", 32'(spi_miso), 32'd0);
      spi_cs_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
